weight_hash_verifier: RTL and testbench
=======================================

Name: weight_hash_verifier

Overview:
Parametrised integrity checker for the weight AXI read channel. It snoops R beats and packs weight beats into 512-bit blocks, then drives an external sha256_core in multi-block mode. Expected 256-bit digests arrive on a separate AXI ID and are queued; each completed bundle is compared against the next queued digest. Results are reported as pulses and counters. This block supersedes the fixed-width, fixed-count hash checker: width, IDs, depths and bundle length are configurable, and FIFO overflow is reported.

Parameters:
AXI_WIDTH, 64, R data width; must be 32, 64, 128 or 256.
AXI_ID_WIDTH, 6, R ID width.
WEIGHT_ID, 0, rid value that carries weight data.
HASH_ID, 1, rid value that carries expected digests.
BLK_FIFO_DEPTH, 4, 512-bit block FIFO depth (power of 2).
HASH_FIFO_DEPTH, 64, expected-digest FIFO depth (power of 2).
CNT_W, 16, width of bundle-length config and counters.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
m_axi_weights_rdata  in  AXI_WIDTH  snooped R data
m_axi_weights_rid  in  AXI_ID_WIDTH  snooped R ID
m_axi_weights_rvalid  in  1  R valid
m_axi_weights_rready  in  1  R ready (observed only, never driven)
cfg_enable  in  1  beat capture enable
cfg_blocks_per_bundle  in  CNT_W  512-bit blocks per bundle; 0 is treated as 1
clear_stats  in  1  one-cycle pulse; clears counters and sticky flags
sha_init  out  1  start-of-message pulse to core
sha_next  out  1  continuation-block pulse to core
sha_block  out  512  block presented to core
sha_ready  in  1  core idle
sha_digest  in  256  core digest
bundle_done  out  1  one-cycle pulse per compared bundle
hash_verified  out  1  one-cycle pulse on match (coincident with bundle_done)
hash_error  out  1  one-cycle pulse on mismatch (coincident with bundle_done)
err_sticky  out  1  set on any mismatch
ovf_sticky  out  1  set on any FIFO overflow
bundles_checked  out  CNT_W  bundles compared, saturating
err_count  out  CNT_W  mismatches, saturating
busy  out  1  FSM not in IDLE, or either FIFO not empty

Behaviour:
- Beat accepted: rvalid && rready && cfg_enable. rid not equal to WEIGHT_ID or HASH_ID is ignored.
- Weight packer, B = 512/AXI_WIDTH: beat k of a block lands in bits [k*AXI_WIDTH +: AXI_WIDTH], beat 0 at LSB. On the B-th beat the block is pushed into the block FIFO on the next cycle.
- Hash packer, H = 256/AXI_WIDTH: same LSB-first packing. The completed digest is pushed into the hash FIFO on the next cycle.
- Interleaved IDs: the two packers keep independent beat counters.
- Overflow: a push to a full FIFO drops the data and sets ovf_sticky. The packer counter still wraps to 0.
- Push and pop in the same cycle are legal when the FIFO is full.
- FSM states:
  - IDLE: when block FIFO is non-empty and sha_ready=1, pop the head into sha_block (held stable until the next issue). Pulse sha_init if blk_cnt==0, else pulse sha_next. Go to WAIT.
  - blk_cnt==0 also latches bundle_len = max(cfg_blocks_per_bundle, 1).
  - WAIT: ignore sha_ready for the first cycle, then wait for sha_ready=1. Increment blk_cnt. If blk_cnt equals bundle_len, go to CMP; else go to IDLE.
  - CMP: wait for hash FIFO non-empty. Compare sha_digest with the FIFO head and pop it. Pulse bundle_done plus exactly one of hash_verified/hash_error. Update counters; set err_sticky on mismatch. Clear blk_cnt and go to IDLE.
- sha_init/sha_next are one-cycle pulses, registered, and never asserted together.
- Latency: result pulses appear 1 cycle after entering CMP with hash data available.
- Counters saturate at all-ones.
- clear_stats clears counters and sticky flags only; it does not disturb the FSM or FIFOs. If clear_stats coincides with an increment, clear wins.
- Reset (including mid-operation): FSM returns to IDLE. Packers, FIFOs, blk_cnt, counters and sticky flags are cleared, and partial blocks are discarded. All outputs are 0, including sha_block.
- cfg_enable low: no new beats are captured. Partial packer contents are retained, and queued blocks keep draining.

Test Plan:
- AXI_WIDTH=64, bundle_len=1, 8 weight beats of the padded SHA-256 "abc" block, then 4 hash beats = ba7816bf…f20015ad -> one sha_init, bundle_done + hash_verified, bundles_checked=1, err_count=0.
- Same stimulus with the expected digest's bit 0 flipped -> hash_error pulse, err_count=1, err_sticky=1; next correct bundle -> hash_verified, err_sticky stays 1.
- bundle_len=2, 16 weight beats of the padded 56-byte NIST "abcdbcdecdefdefg…nopq" message -> sha_init then sha_next, digest 248d6a61…19db06c1 verified.
- Interleave hash beats between weight beats (rid alternating 0/1/3) -> rid 3 ignored, result identical to the non-interleaved run.
- Hold sha_ready low for 6 full blocks with BLK_FIFO_DEPTH=4 -> ovf_sticky=1, 4 blocks retained; clear_stats -> ovf_sticky=0.
- Assert rstn low after 5 of 8 beats, then send a fresh 8-beat block -> partial beats discarded, the fresh block hashes correctly.

Source files
------------

// File: rtl/weight_hash_verifier.sv
// Weight-stream integrity checker.
// Snoops AXI R beats and packs weight beats into 512-bit blocks for an
// external SHA-256 core. Expected digests arrive on a separate ID and are
// queued. Each finished bundle's digest is compared with the next queued one.
module weight_hash_verifier #(
  parameter int AXI_WIDTH       = 64,
  parameter int AXI_ID_WIDTH    = 6,
  parameter int WEIGHT_ID       = 0,
  parameter int HASH_ID         = 1,
  parameter int BLK_FIFO_DEPTH  = 4,
  parameter int HASH_FIFO_DEPTH = 64,
  parameter int CNT_W           = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [AXI_WIDTH-1:0]    m_axi_weights_rdata,
  input  logic [AXI_ID_WIDTH-1:0] m_axi_weights_rid,
  input  logic                    m_axi_weights_rvalid,
  input  logic                    m_axi_weights_rready,
  input  logic                    cfg_enable,
  input  logic [CNT_W-1:0]        cfg_blocks_per_bundle,
  input  logic                    clear_stats,
  output logic                    sha_init,
  output logic                    sha_next,
  output logic [511:0]            sha_block,
  input  logic                    sha_ready,
  input  logic [255:0]            sha_digest,
  output logic                    bundle_done,
  output logic                    hash_verified,
  output logic                    hash_error,
  output logic                    err_sticky,
  output logic                    ovf_sticky,
  output logic [CNT_W-1:0]        bundles_checked,
  output logic [CNT_W-1:0]        err_count,
  output logic                    busy
);

  localparam int B   = 512 / AXI_WIDTH;
  localparam int H   = 256 / AXI_WIDTH;
  localparam int BCW = (B > 1) ? $clog2(B) : 1;
  localparam int HCW = (H > 1) ? $clog2(H) : 1;
  localparam int BAW = $clog2(BLK_FIFO_DEPTH);
  localparam int HAW = $clog2(HASH_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, CMP} state_t;

  logic beat_ok, w_beat, h_beat;
  assign beat_ok = m_axi_weights_rvalid && m_axi_weights_rready && cfg_enable;
  assign w_beat  = beat_ok && (m_axi_weights_rid == AXI_ID_WIDTH'(WEIGHT_ID));
  assign h_beat  = beat_ok && (m_axi_weights_rid == AXI_ID_WIDTH'(HASH_ID));

  logic [BCW-1:0] wcnt_reg;
  logic [HCW-1:0] hcnt_reg;
  logic           wpush_reg, hpush_reg;
  wire  [511:0]   wblock;
  wire  [255:0]   hblock;

  // Beat counters; a completed block/digest is pushed on the following cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wcnt_reg  <= '0;
      hcnt_reg  <= '0;
      wpush_reg <= 1'b0;
      hpush_reg <= 1'b0;
    end else begin
      wpush_reg <= 1'b0;
      hpush_reg <= 1'b0;
      if (w_beat) begin
        if (wcnt_reg == BCW'(B - 1)) begin
          wcnt_reg  <= '0;
          wpush_reg <= 1'b1;
        end else begin
          wcnt_reg <= wcnt_reg + 1'b1;
        end
      end
      if (h_beat) begin
        if (hcnt_reg == HCW'(H - 1)) begin
          hcnt_reg  <= '0;
          hpush_reg <= 1'b1;
        end else begin
          hcnt_reg <= hcnt_reg + 1'b1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < B; gi++) begin : g_wlane
      logic [AXI_WIDTH-1:0] lane_reg;
      // Weight lane gi captures beat gi of the current block (LSB first)
      always_ff @(posedge clk) begin
        if (!rstn) lane_reg <= '0;
        else if (w_beat && wcnt_reg == BCW'(gi)) lane_reg <= m_axi_weights_rdata;
      end
      assign wblock[gi*AXI_WIDTH +: AXI_WIDTH] = lane_reg;
    end
    for (gi = 0; gi < H; gi++) begin : g_hlane
      logic [AXI_WIDTH-1:0] lane_reg;
      // Digest lane gi captures beat gi of the current expected digest
      always_ff @(posedge clk) begin
        if (!rstn) lane_reg <= '0;
        else if (h_beat && hcnt_reg == HCW'(gi)) lane_reg <= m_axi_weights_rdata;
      end
      assign hblock[gi*AXI_WIDTH +: AXI_WIDTH] = lane_reg;
    end
  endgenerate

  // Block and digest FIFOs: extra pointer bit distinguishes full from empty
  logic [511:0] blk_mem  [BLK_FIFO_DEPTH];
  logic [255:0] hash_mem [HASH_FIFO_DEPTH];
  logic [BAW:0] blk_wr_reg, blk_rd_reg;
  logic [HAW:0] hash_wr_reg, hash_rd_reg;
  logic blk_empty, blk_full, hash_empty, hash_full;
  logic blk_pop, hash_pop, blk_wr_ok, hash_wr_ok, ovf_set, match;
  state_t state_reg;

  assign blk_empty  = (blk_wr_reg == blk_rd_reg);
  assign blk_full   = (blk_wr_reg[BAW] != blk_rd_reg[BAW]) &&
                      (blk_wr_reg[BAW-1:0] == blk_rd_reg[BAW-1:0]);
  assign hash_empty = (hash_wr_reg == hash_rd_reg);
  assign hash_full  = (hash_wr_reg[HAW] != hash_rd_reg[HAW]) &&
                      (hash_wr_reg[HAW-1:0] == hash_rd_reg[HAW-1:0]);
  assign blk_pop    = (state_reg == IDLE) && !blk_empty && sha_ready;
  assign hash_pop   = (state_reg == CMP) && !hash_empty;
  // A pop in the same cycle frees the slot, so a push to a full FIFO is kept
  assign blk_wr_ok  = wpush_reg && (!blk_full || blk_pop);
  assign hash_wr_ok = hpush_reg && (!hash_full || hash_pop);
  assign ovf_set    = (wpush_reg && !blk_wr_ok) || (hpush_reg && !hash_wr_ok);
  assign match      = (sha_digest == hash_mem[hash_rd_reg[HAW-1:0]]);

  // FIFO storage writes (no reset: contents are qualified by the pointers)
  always_ff @(posedge clk) begin
    if (blk_wr_ok)  blk_mem[blk_wr_reg[BAW-1:0]]   <= wblock;
    if (hash_wr_ok) hash_mem[hash_wr_reg[HAW-1:0]] <= hblock;
  end

  // FIFO pointer maintenance
  always_ff @(posedge clk) begin
    if (!rstn) begin
      blk_wr_reg  <= '0;
      blk_rd_reg  <= '0;
      hash_wr_reg <= '0;
      hash_rd_reg <= '0;
    end else begin
      if (blk_wr_ok)  blk_wr_reg  <= blk_wr_reg + 1'b1;
      if (blk_pop)    blk_rd_reg  <= blk_rd_reg + 1'b1;
      if (hash_wr_ok) hash_wr_reg <= hash_wr_reg + 1'b1;
      if (hash_pop)   hash_rd_reg <= hash_rd_reg + 1'b1;
    end
  end

  logic [CNT_W-1:0] blk_cnt_reg, bundle_len_reg, blk_cnt_inc;
  logic [511:0]     sha_block_reg;
  logic sha_init_reg, sha_next_reg, wait_first_reg;
  logic bundle_done_reg, hash_verified_reg, hash_error_reg;
  assign blk_cnt_inc = blk_cnt_reg + 1'b1;

  // Control FSM: issue blocks to the core, count a bundle, then compare
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg         <= IDLE;
      blk_cnt_reg       <= '0;
      bundle_len_reg    <= '0;
      sha_block_reg     <= '0;
      sha_init_reg      <= 1'b0;
      sha_next_reg      <= 1'b0;
      wait_first_reg    <= 1'b0;
      bundle_done_reg   <= 1'b0;
      hash_verified_reg <= 1'b0;
      hash_error_reg    <= 1'b0;
    end else begin
      sha_init_reg      <= 1'b0;
      sha_next_reg      <= 1'b0;
      bundle_done_reg   <= 1'b0;
      hash_verified_reg <= 1'b0;
      hash_error_reg    <= 1'b0;
      case (state_reg)
        IDLE: if (blk_pop) begin
          sha_block_reg <= blk_mem[blk_rd_reg[BAW-1:0]];
          if (blk_cnt_reg == '0) begin
            sha_init_reg   <= 1'b1;
            bundle_len_reg <= (cfg_blocks_per_bundle == '0) ? CNT_W'(1) : cfg_blocks_per_bundle;
          end else begin
            sha_next_reg <= 1'b1;
          end
          wait_first_reg <= 1'b1;
          state_reg      <= WAIT;
        end
        // First WAIT cycle: the core has not yet seen the start pulse
        WAIT: if (wait_first_reg) begin
          wait_first_reg <= 1'b0;
        end else if (sha_ready) begin
          blk_cnt_reg <= blk_cnt_inc;
          state_reg   <= (blk_cnt_inc == bundle_len_reg) ? CMP : IDLE;
        end
        CMP: if (hash_pop) begin
          bundle_done_reg   <= 1'b1;
          hash_verified_reg <= match;
          hash_error_reg    <= !match;
          blk_cnt_reg       <= '0;
          state_reg         <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [CNT_W-1:0] bundles_reg, errs_reg;
  logic err_sticky_reg, ovf_sticky_reg;

  // Statistics: saturating counters and sticky flags; clear beats increments
  always_ff @(posedge clk) begin
    if (!rstn || clear_stats) begin
      bundles_reg    <= '0;
      errs_reg       <= '0;
      err_sticky_reg <= 1'b0;
      ovf_sticky_reg <= 1'b0;
    end else begin
      if (hash_pop) begin
        if (bundles_reg != '1) bundles_reg <= bundles_reg + 1'b1;
        if (!match) begin
          err_sticky_reg <= 1'b1;
          if (errs_reg != '1) errs_reg <= errs_reg + 1'b1;
        end
      end
      if (ovf_set) ovf_sticky_reg <= 1'b1;
    end
  end

  assign sha_init        = sha_init_reg;
  assign sha_next        = sha_next_reg;
  assign sha_block       = sha_block_reg;
  assign bundle_done     = bundle_done_reg;
  assign hash_verified   = hash_verified_reg;
  assign hash_error      = hash_error_reg;
  assign err_sticky      = err_sticky_reg;
  assign ovf_sticky      = ovf_sticky_reg;
  assign bundles_checked = bundles_reg;
  assign err_count       = errs_reg;
  assign busy            = (state_reg != IDLE) || !blk_empty || !hash_empty;

endmodule

// File: tb/tb_weight_hash_verifier.sv
// Directed bench for weight_hash_verifier (AXI_WIDTH=64, 4-deep block FIFO).
// A small SHA core stand-in recognises the known NIST message blocks and
// returns their published digests, anything else yields a junk digest.
module tb_weight_hash_verifier;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_D   =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0] N1_BLK  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] N2_BLK  = {480'h0, 32'h000001c0};
  localparam logic [255:0] N_D     =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk = 1'b0;
  logic         rstn;
  logic [63:0]  rdata;
  logic [5:0]   rid;
  logic         rvalid, rready, cfg_enable, clear_stats;
  logic [15:0]  cfg_bpb;
  logic         sha_init, sha_next, sha_ready = 1'b0;
  logic [511:0] sha_block;
  logic [255:0] sha_digest = '0;
  logic         bundle_done, hash_verified, hash_error, err_sticky, ovf_sticky, busy;
  logic [15:0]  bundles_checked, err_count;

  int checks = 0;
  int errors = 0;
  int init_cnt = 0;
  int next_cnt = 0;
  int core_busy = 0;
  int stage = 0;
  logic core_hold = 1'b0;
  int base_init;

  always #5 clk = ~clk;

  weight_hash_verifier dut (
    .clk(clk), .rstn(rstn),
    .m_axi_weights_rdata(rdata), .m_axi_weights_rid(rid),
    .m_axi_weights_rvalid(rvalid), .m_axi_weights_rready(rready),
    .cfg_enable(cfg_enable), .cfg_blocks_per_bundle(cfg_bpb), .clear_stats(clear_stats),
    .sha_init(sha_init), .sha_next(sha_next), .sha_block(sha_block),
    .sha_ready(sha_ready), .sha_digest(sha_digest),
    .bundle_done(bundle_done), .hash_verified(hash_verified), .hash_error(hash_error),
    .err_sticky(err_sticky), .ovf_sticky(ovf_sticky),
    .bundles_checked(bundles_checked), .err_count(err_count), .busy(busy)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Core stand-in, sampled on the falling edge away from the DUT's clock edge
  always @(negedge clk) begin
    if (!rstn) begin
      sha_ready = 1'b1;
      core_busy = 0;
      stage     = 0;
    end else if (sha_init || sha_next) begin
      if (sha_init && sha_next) check("init_next_exclusive", 1, 0);
      if (sha_init) begin
        init_cnt++;
        stage = 0;
        if (sha_block == ABC_BLK) sha_digest = ABC_D;
        else if (sha_block == N1_BLK) begin sha_digest = '0; stage = 1; end
        else sha_digest = 256'hdead;
      end else begin
        next_cnt++;
        sha_digest = (stage == 1 && sha_block == N2_BLK) ? N_D : 256'hbad;
        stage = 0;
      end
      sha_ready = 1'b0;
      core_busy = 4;
    end else if (core_busy > 0) begin
      core_busy--;
      if (core_busy == 0) sha_ready = !core_hold;
    end else begin
      sha_ready = !core_hold;
    end
  end

  task automatic beat(input logic [5:0] id, input logic [63:0] d);
    rvalid = 1'b1; rready = 1'b1; rid = id; rdata = d;
    @(negedge clk);
    rvalid = 1'b0;
  endtask

  task automatic send_block(input logic [511:0] blk);
    for (int k = 0; k < 8; k++) beat(6'd0, blk[k*64 +: 64]);
  endtask

  task automatic send_hash(input logic [255:0] d);
    for (int k = 0; k < 4; k++) beat(6'd1, d[k*64 +: 64]);
  endtask

  task automatic wait_result(input string tag, input logic exp_ver);
    int n = 0;
    while (!bundle_done && n < 400) begin @(negedge clk); n++; end
    check({tag, "_done"}, bundle_done, 1'b1);
    check({tag, "_verified"}, hash_verified, exp_ver);
    check({tag, "_error"}, hash_error, !exp_ver);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; rvalid = 1'b0; rready = 1'b0; rid = '0; rdata = '0;
    cfg_enable = 1'b1; clear_stats = 1'b0; cfg_bpb = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_sha_init", sha_init, 0);
    check("rst_sha_block", sha_block, 0);
    check("rst_busy", busy, 0);
    check("rst_bundles", bundles_checked, 0);
    check("rst_sticky", {err_sticky, ovf_sticky}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // abc, bundle length 0 treated as 1
    send_block(ABC_BLK);
    send_hash(ABC_D);
    wait_result("abc", 1'b1);
    check("abc_bundles", bundles_checked, 1);
    check("abc_errcnt", err_count, 0);
    check("abc_inits", init_cnt, 1);
    check("abc_nexts", next_cnt, 0);
    check("abc_block_held", sha_block, ABC_BLK);

    // Flipped expected digest, then a correct bundle
    send_block(ABC_BLK);
    send_hash(ABC_D ^ 256'h1);
    wait_result("bad", 1'b0);
    check("bad_errcnt", err_count, 1);
    check("bad_sticky", err_sticky, 1);
    send_block(ABC_BLK);
    send_hash(ABC_D);
    wait_result("good_after_bad", 1'b1);
    check("still_sticky", err_sticky, 1);
    check("bundles3", bundles_checked, 3);

    // Two-block NIST message
    cfg_bpb = 16'd2;
    send_block(N1_BLK);
    send_block(N2_BLK);
    send_hash(N_D);
    wait_result("nist2", 1'b1);
    check("nist_inits", init_cnt, 2 + 2);
    check("nist_nexts", next_cnt, 1);
    check("nist_errcnt", err_count, 1);

    // Interleaved rids 0/1/3
    cfg_bpb = 16'd1;
    for (int k = 0; k < 8; k++) begin
      beat(6'd0, ABC_BLK[k*64 +: 64]);
      if (k < 4) beat(6'd1, ABC_D[k*64 +: 64]);
      beat(6'd3, {$urandom, $urandom});
    end
    wait_result("interleave", 1'b1);
    check("interleave_bundles", bundles_checked, 5);

    // Overflow: core held busy while 6 blocks arrive
    core_hold = 1'b1;
    repeat (2) @(negedge clk);
    base_init = init_cnt;
    for (int b = 0; b < 6; b++) send_block(ABC_BLK);
    for (int b = 0; b < 4; b++) send_hash(ABC_D);
    check("ovf_sticky", ovf_sticky, 1);
    check("ovf_busy", busy, 1);
    check("ovf_no_issue", init_cnt, base_init);
    core_hold = 1'b0;
    for (int b = 0; b < 4; b++) wait_result("ovf_drain", 1'b1);
    repeat (30) @(negedge clk);
    check("ovf_retained4", init_cnt - base_init, 4);
    check("ovf_idle", busy, 0);
    check("ovf_bundles", bundles_checked, 9);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    check("clr_ovf", ovf_sticky, 0);
    check("clr_err", err_sticky, 0);
    check("clr_counts", {bundles_checked, err_count}, 0);

    // Capture disabled: beats ignored
    cfg_enable = 1'b0;
    send_block(ABC_BLK);
    repeat (5) @(negedge clk);
    check("disabled_idle", busy, 0);
    cfg_enable = 1'b1;

    // Reset mid-operation: bundle waiting in CMP plus 5 partial beats
    send_block(ABC_BLK);
    for (int k = 0; k < 5; k++) beat(6'd0, N1_BLK[k*64 +: 64]);
    check("pre_reset_busy", busy, 1);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_block", sha_block, 0);
    rstn = 1'b1;
    @(negedge clk);
    send_block(ABC_BLK);
    send_hash(ABC_D);
    wait_result("after_reset", 1'b1);
    check("after_reset_bundles", bundles_checked, 1);
    check("after_reset_errs", err_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
